// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO sitting in front of a UART transmitter.
// The bus side pushes bytes and watches full/level; a small FSM pops one byte
// at a time and paces it against the UART ss strobe / busy handshake.
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int AW            = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int BUSY_TIMEOUT  = 255
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        flush,
  input  logic        clr_status,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        overflow,
  output logic        tx_err,
  output logic        tx_ss,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        tx_active
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STROBE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  localparam logic [AW:0] LP_ONE         = (AW+1)'(1);
  localparam logic [AW:0] LP_DEPTH       = (AW+1)'(DEPTH);
  localparam logic [3:0]  LP_STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [7:0]  LP_TMO_LAST    = 8'(BUSY_TIMEOUT - 1);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] r_level;
  logic        r_full;
  logic        r_empty;
  logic        r_overflow;
  logic        r_txErr;
  logic        r_txSs;
  logic [7:0]  r_txData;
  logic        r_busyMeta;
  logic        r_busyS;
  state_t      r_state;
  logic [3:0]  r_strobeCnt;
  logic [7:0]  r_busyCnt;

  logic        w_push;
  logic        w_pushDrop;
  logic        w_pop;
  logic        w_timeout;
  logic [AW:0] w_wptrNext;
  logic [AW:0] w_rptrNext;
  logic [AW:0] w_levelNext;

  // Flush beats a same-cycle push, and fullness is judged on the pre-edge state.
  assign w_push      = wr_en & ~flush & ~r_full;
  assign w_pushDrop  = wr_en & ~flush & r_full;
  assign w_pop       = (r_state == ST_LOAD);
  assign w_timeout   = (r_state == ST_WAIT_BUSY) & ~r_busyS & (r_busyCnt == LP_TMO_LAST);
  assign w_wptrNext  = w_push ? (r_wptr + LP_ONE) : r_wptr;
  assign w_rptrNext  = flush ? r_wptr : (w_pop ? (r_rptr + LP_ONE) : r_rptr);
  assign w_levelNext = w_wptrNext - w_rptrNext;

  assign full      = r_full;
  assign empty     = r_empty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign tx_err    = r_txErr;
  assign tx_ss     = r_txSs;
  assign tx_data   = r_txData;
  assign tx_active = (r_state != ST_IDLE);

  // Two-flop synchroniser for the UART busy flag, which lives in another clock domain.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_busyMeta <= 1'b0;
      r_busyS    <= 1'b0;
    end else begin
      r_busyMeta <= tx_busy;
      r_busyS    <= r_busyMeta;
    end
  end

  // Storage array; contents are don't-care after reset since the pointers say what is valid.
  always_ff @(posedge sclk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers plus registered occupancy flags computed from the next pointer values.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptrNext;
      r_rptr  <= w_rptrNext;
      r_level <= w_levelNext;
      r_full  <= (w_levelNext == LP_DEPTH);
      r_empty <= (w_levelNext == '0);
    end
  end

  // Sticky status flags; a setting event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_txErr    <= 1'b0;
    end else begin
      if (w_pushDrop) begin
        r_overflow <= 1'b1;
      end else if (clr_status) begin
        r_overflow <= 1'b0;
      end
      if (w_timeout) begin
        r_txErr <= 1'b1;
      end else if (clr_status) begin
        r_txErr <= 1'b0;
      end
    end
  end

  // Transmit sequencer: pop a byte, strobe the UART, then follow its busy pulse.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_txSs      <= 1'b0;
      r_txData    <= 8'h00;
      r_strobeCnt <= '0;
      r_busyCnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (~r_empty & ~r_busyS & ~flush) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_txData    <= r_mem[r_rptr[AW-1:0]];
          r_txSs      <= 1'b1;
          r_strobeCnt <= '0;
          r_state     <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_strobeCnt == LP_STROBE_LAST) begin
            r_txSs    <= 1'b0;
            r_busyCnt <= '0;
            r_state   <= ST_WAIT_BUSY;
          end else begin
            r_strobeCnt <= r_strobeCnt + 4'd1;
          end
        end
        ST_WAIT_BUSY: begin
          if (r_busyS) begin
            r_state <= ST_WAIT_DONE;
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
          end else begin
            r_busyCnt <= r_busyCnt + 8'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (~r_busyS) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: drives uart_tx_fifo with a behavioural UART busy model and
// compares every strobed byte against a queue of bytes the bench expects to see.
module tb_uart_tx_fifo;

  logic       sclk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_status;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_err;
  logic       tx_ss;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       tx_active;

  typedef enum int {UART_NORMAL, UART_HOLD, UART_DEAD} uartMode_t;

  typedef struct {
    logic       we;
    logic [7:0] data;
    logic       fl;
    logic       clr;
    logic       accept;
    int         expLevel;
    logic       expFull;
    logic       expEmpty;
    logic       expOvf;
  } vec_t;

  uartMode_t  uartMode = UART_NORMAL;
  logic [7:0] expQ[$];
  vec_t       vecs[$];
  int         total = 0;
  int         bad = 0;
  int         strobeCount = 0;
  logic       prevSs = 1'b0;
  int         delayCnt = 0;
  int         busyCnt = 0;
  logic       ssSeen = 1'b0;

  uart_tx_fifo #(
    .DEPTH(16),
    .AW(4),
    .STROBE_CYCLES(2),
    .BUSY_TIMEOUT(255)
  ) dut (
    .sclk(sclk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .flush(flush),
    .clr_status(clr_status),
    .full(full),
    .empty(empty),
    .level(level),
    .overflow(overflow),
    .tx_err(tx_err),
    .tx_ss(tx_ss),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_active(tx_active)
  );

  // Free-running system clock.
  always #5 sclk = ~sclk;

  // UART model: busy rises a few cycles after a strobe and falls after a fixed time,
  // or is forced high (hold) or never raised (dead).
  always begin
    @(posedge sclk);
    #1;
    if (uartMode == UART_HOLD) begin
      tx_busy  = 1'b1;
      delayCnt = 0;
      busyCnt  = 0;
      ssSeen   = tx_ss;
    end else if (uartMode == UART_DEAD) begin
      tx_busy  = 1'b0;
      delayCnt = 0;
      busyCnt  = 0;
      ssSeen   = tx_ss;
    end else begin
      if (tx_ss && !ssSeen) delayCnt = 3;
      ssSeen = tx_ss;
      if (delayCnt > 0) begin
        delayCnt--;
        if (delayCnt == 0) begin
          tx_busy = 1'b1;
          busyCnt = 6;
        end
      end else if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) tx_busy = 1'b0;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // One clock cycle; on a rising strobe the byte on tx_data is checked against the queue.
  task automatic tick();
    logic [7:0] want;
    @(negedge sclk);
    if (tx_ss && !prevSs) begin
      strobeCount++;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedStrobe: got byte %0h want no strobe", tx_data);
      end else begin
        want = expQ.pop_front();
        checkOutput("strobeData", {24'h0, tx_data}, {24'h0, want});
      end
    end
    prevSs = tx_ss;
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] d, input logic fl, input logic clr);
    wr_en      = we;
    wr_data    = d;
    flush      = fl;
    clr_status = clr;
    tick();
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    flush      = 1'b0;
    clr_status = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] d, input logic accept);
    if (accept) expQ.push_back(d);
    applyStimulus(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic waitSsHigh(input string name);
    int n = 0;
    while (!tx_ss && n < 200) begin
      tick();
      n++;
    end
    checkOutput(name, tx_ss, 1);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (!(empty && !tx_active) && n < 2000) begin
      tick();
      n++;
    end
    checkOutput(name, {empty, tx_active}, 2'b10);
    checkOutput({name, "Sb"}, expQ.size(), 0);
  endtask

  initial begin
    int n;
    int sc;

    for (int i = 0; i < 16; i++) begin
      vecs.push_back('{1'b1, 8'(i), 1'b0, 1'b0, 1'b1, i + 1, (i == 15), 1'b0, 1'b0});
    end
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'hFD, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1});

    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    flush      = 1'b0;
    clr_status = 1'b0;
    repeat (2) tick();
    checkOutput("rstFull", full, 0);
    checkOutput("rstEmpty", empty, 1);
    checkOutput("rstLevel", level, 0);
    checkOutput("rstOverflow", overflow, 0);
    checkOutput("rstTxErr", tx_err, 0);
    checkOutput("rstTxSs", tx_ss, 0);
    checkOutput("rstTxData", tx_data, 0);
    checkOutput("rstActive", tx_active, 0);
    reset = 1'b0;
    repeat (3) tick();

    $display("[TB] single byte timing");
    pushByte(8'hA5, 1'b1);
    checkOutput("t1EmptyAfterPush", empty, 0);
    checkOutput("t1LevelAfterPush", level, 1);
    tick();
    checkOutput("t1LoadActive", tx_active, 1);
    checkOutput("t1LoadSs", tx_ss, 0);
    tick();
    checkOutput("t1SsCycle1", tx_ss, 1);
    checkOutput("t1Data", tx_data, 8'hA5);
    checkOutput("t1LevelPopped", level, 0);
    tick();
    checkOutput("t1SsCycle2", tx_ss, 1);
    tick();
    checkOutput("t1SsDrop", tx_ss, 0);
    n = 0;
    while (!tx_busy && n < 50) begin tick(); n++; end
    checkOutput("t1BusyRise", tx_busy, 1);
    n = 0;
    while (tx_busy && n < 50) begin tick(); n++; end
    checkOutput("t1BusyFall", tx_busy, 0);
    repeat (2) tick();
    checkOutput("t1ActiveDuringSync", tx_active, 1);
    tick();
    checkOutput("t1ActiveLow", tx_active, 0);
    checkOutput("t1EmptyEnd", empty, 1);
    checkOutput("t1DataHeld", tx_data, 8'hA5);
    checkOutput("t1Sb", expQ.size(), 0);

    $display("[TB] fill to full with UART held busy");
    uartMode = UART_HOLD;
    repeat (4) tick();
    foreach (vecs[i]) begin
      if (vecs[i].we && vecs[i].accept) expQ.push_back(vecs[i].data);
      applyStimulus(vecs[i].we, vecs[i].data, vecs[i].fl, vecs[i].clr);
      checkOutput($sformatf("vecLevel%0d", i), level, vecs[i].expLevel);
      checkOutput($sformatf("vecFull%0d", i), full, vecs[i].expFull);
      checkOutput($sformatf("vecEmpty%0d", i), empty, vecs[i].expEmpty);
      checkOutput($sformatf("vecOvf%0d", i), overflow, vecs[i].expOvf);
    end
    checkOutput("t2NoStrobeWhileBusy", strobeCount, 1);
    uartMode = UART_NORMAL;
    waitDrain("t2Drain");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t2OvfCleared", overflow, 0);

    $display("[TB] bursts across pointer wrap");
    for (int b = 0; b < 3; b++) begin
      uartMode = UART_HOLD;
      repeat (4) tick();
      for (int k = 0; k < ((b == 2) ? 6 : 7); k++) begin
        pushByte(8'h30 + 8'(b * 7 + k), 1'b1);
        checkOutput($sformatf("t3Level%0d_%0d", b, k), level, k + 1);
      end
      uartMode = UART_NORMAL;
      waitDrain($sformatf("t3Drain%0d", b));
    end

    $display("[TB] flush during transfer");
    uartMode = UART_HOLD;
    repeat (4) tick();
    for (int k = 0; k < 5; k++) pushByte(8'h41 + 8'(k), 1'b1);
    checkOutput("t4Level5", level, 5);
    uartMode = UART_NORMAL;
    waitSsHigh("t4FirstStrobe");
    n = 0;
    while (!tx_busy && n < 50) begin tick(); n++; end
    checkOutput("t4BusySeen", tx_busy, 1);
    repeat (3) tick();
    checkOutput("t4InWaitDone", {tx_active, tx_ss}, 2'b10);
    sc = strobeCount;
    expQ.delete();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t4FlushLevel", level, 0);
    checkOutput("t4FlushEmpty", empty, 1);
    n = 0;
    while (tx_active && n < 100) begin tick(); n++; end
    checkOutput("t4FirstCompletes", tx_active, 0);
    repeat (40) tick();
    checkOutput("t4NoMoreStrobes", strobeCount, sc);
    uartMode = UART_HOLD;
    repeat (4) tick();
    for (int k = 0; k < 16; k++) pushByte(8'h60 + 8'(k), 1'b1);
    checkOutput("t4Full", full, 1);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    expQ.delete();
    checkOutput("t4FlushWrLevel", level, 0);
    checkOutput("t4FlushWrOvf", overflow, 0);
    checkOutput("t4FlushWrFull", full, 0);
    checkOutput("t4FlushWrEmpty", empty, 1);
    sc = strobeCount;
    uartMode = UART_NORMAL;
    repeat (40) tick();
    checkOutput("t4NoStrobeAfterFlush", strobeCount, sc);

    $display("[TB] busy timeout");
    uartMode = UART_DEAD;
    repeat (3) tick();
    pushByte(8'hC1, 1'b1);
    pushByte(8'hC2, 1'b1);
    waitSsHigh("t5Strobe1");
    n = 0;
    while (tx_ss && n < 20) begin tick(); n++; end
    n = 0;
    while (!tx_err && n < 400) begin tick(); n++; end
    checkOutput("t5TimeoutCycles", n, 255);
    checkOutput("t5ErrSet", tx_err, 1);
    checkOutput("t5Idle", tx_active, 0);
    waitSsHigh("t5Strobe2");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t5ErrClr", tx_err, 0);
    n = 0;
    while (!tx_err && n < 400) begin tick(); n++; end
    checkOutput("t5ErrSetAgain", tx_err, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t5ErrClr2", tx_err, 0);
    checkOutput("t5Sb", expQ.size(), 0);
    uartMode = UART_NORMAL;
    repeat (4) tick();

    $display("[TB] reset during strobe");
    pushByte(8'h5A, 1'b1);
    pushByte(8'h5B, 1'b1);
    waitSsHigh("t6Strobe");
    checkOutput("t6LevelBefore", level, 1);
    reset = 1'b1;
    #1;
    checkOutput("t6TxSs", tx_ss, 0);
    checkOutput("t6TxData", tx_data, 0);
    checkOutput("t6Active", tx_active, 0);
    checkOutput("t6Level", level, 0);
    checkOutput("t6Empty", empty, 1);
    checkOutput("t6Full", full, 0);
    expQ.delete();
    prevSs = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    sc = strobeCount;
    repeat (30) tick();
    checkOutput("t6NoStrobeAfterReset", strobeCount, sc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
